// File: rtl/store_buffer.sv
// Circular store buffer between the CPU MEM stage and dcache. Drains one entry per cycle when the port is free.
// Define SB_FORWARD_EN to forward buffered data on load hits; otherwise hits stall until the entry drains.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_w_en,
  input  logic              cpu_r_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              dc_w_en,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic [DATA_W-1:0] dc_rdata,
  output logic              sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  logic              full;
  logic              match;
  logic              load_hazard_stall;
  logic              drain_go;
  logic              enq;
  logic [PTR_W-1:0]  idx;
`ifdef SB_FORWARD_EN
  logic [DATA_W-1:0] fwd_data;
`endif

  assign full     = (count_q == FULL_CNT);
  assign sb_empty = (count_q == '0);

  // Scan oldest to youngest so the last hit is the entry nearest tail.
  always_comb begin
    match = 1'b0;
    idx   = '0;
`ifdef SB_FORWARD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == cpu_addr)) begin
        match = 1'b1;
`ifdef SB_FORWARD_EN
        fwd_data = data_q[idx];
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  assign load_hazard_stall = 1'b0;
  assign cpu_rdata = (cpu_r_en && match) ? fwd_data : dc_rdata;
`else
  assign load_hazard_stall = cpu_r_en && match;
  assign cpu_rdata = dc_rdata;
`endif

  // Drain is masked during reset so discarded entries never reach dcache.
  assign drain_go  = !reset && (count_q != '0) && (!cpu_r_en || load_hazard_stall);
  assign enq       = !reset && cpu_w_en && !cpu_r_en && !full;
  assign cpu_stall = (cpu_w_en && (cpu_r_en || full)) || load_hazard_stall;

  assign dc_w_en  = drain_go;
  assign dc_addr  = drain_go ? addr_q[head_q] : cpu_addr;
  assign dc_wdata = drain_go ? data_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (drain_go) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (enq) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_W'(1);
    end
    case ({enq, drain_go})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
// Includes a simple combinational-read dcache; honours SB_FORWARD_EN like the design.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              cpu_w_en;
  logic              cpu_r_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dc_w_en;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              sb_empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_w_en(cpu_w_en), .cpu_r_en(cpu_r_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dc_w_en(dc_w_en), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dcache: combinational read, write at the clock edge
  logic [DATA_W-1:0] dmem [64];
  assign dc_rdata = dmem[dc_addr];
  always @(posedge clk) if (dc_w_en) dmem[dc_addr] <= dc_wdata;

  // reference model: pending stores in program order plus the expected memory image
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t              sbq[$];
  logic [DATA_W-1:0] ref_mem [64];

  int n_checks = 0;
  int n_errs   = 0;
  bit last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step(input bit rst, input bit w, input bit r,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int cnt;
    bit hit, hz, fwd, stall, drain;
    logic [DATA_W-1:0] hit_data;
    @(negedge clk);
    reset = rst; cpu_w_en = w; cpu_r_en = r; cpu_addr = a; cpu_wdata = d;
    #1;
    cnt = sbq.size();
    hit = 1'b0; hit_data = '0;
    foreach (sbq[k]) if (sbq[k].addr == a) begin hit = 1'b1; hit_data = sbq[k].data; end
    hz = 1'b0; fwd = 1'b0;
`ifdef SB_FORWARD_EN
    fwd = r && hit;
`else
    hz = r && hit;
`endif
    stall = (w && (r || cnt == DEPTH)) || hz;
    drain = !rst && cnt > 0 && (!r || hz);
    check("dc_w_en", 32'(dc_w_en), 32'(drain));
    if (!rst) begin
      check("cpu_stall", 32'(cpu_stall), 32'(stall));
      check("sb_empty", 32'(sb_empty), 32'(cnt == 0));
      if (drain) begin
        check("dc_addr_drain", 32'(dc_addr), 32'(sbq[0].addr));
        check("dc_wdata_drain", dc_wdata, sbq[0].data);
      end else begin
        check("dc_addr_cpu", 32'(dc_addr), 32'(a));
        check("dc_wdata_idle", dc_wdata, 32'h0);
      end
      if (r && !hz) check("cpu_rdata", cpu_rdata, fwd ? hit_data : ref_mem[a]);
    end
    last_stall = stall;
    if (rst) begin
      sbq.delete();
    end else begin
      if (drain) begin
        ref_mem[sbq[0].addr] = sbq[0].data;
        void'(sbq.pop_front());
      end
      if (w && !r && cnt < DEPTH) sbq.push_back('{addr: a, data: d});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bit pw, pr, hold;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    int tries;

    reset = 1'b1; cpu_w_en = 1'b0; cpu_r_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dmem[i]    = 32'hC0DE_0000 + 32'(i);
      ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    end

    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(1);
    check("reset_empty", 32'(sb_empty), 32'd1);

    // single store drains the next cycle
    step(1'b0, 1'b1, 1'b0, 6'd5, 32'hDEADBEEF);
    idle(2);
    check("mem5", dmem[5], 32'hDEADBEEF);

    // stores interleaved with loads to an unrelated address
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 6'(i), 32'h100 + 32'(i));
      step(1'b0, 1'b0, 1'b1, 6'd60, '0);
    end
    step(1'b0, 1'b1, 1'b1, 6'd60, 32'h55);
    idle(6);
    check("mem4", dmem[4], 32'h104);

    // two stores to one address, then a load of it
    step(1'b0, 1'b1, 1'b0, 6'd7, 32'h11);
    step(1'b0, 1'b1, 1'b0, 6'd7, 32'h22);
    tries = 0;
    do begin
      step(1'b0, 1'b0, 1'b1, 6'd7, '0);
      tries++;
    end while (last_stall && tries < 8);
    check("load7_released", 32'(cpu_stall), 32'd0);
    check("load7_data", cpu_rdata, 32'h22);
    idle(2);

    // unrelated load leaves the buffered entry in place
    step(1'b0, 1'b1, 1'b0, 6'd3, 32'h33);
    step(1'b0, 1'b0, 1'b1, 6'd9, '0);
    step(1'b0, 1'b0, 1'b1, 6'd9, '0);
    check("entry3_held", 32'(sb_empty), 32'd0);
    idle(2);

    // reset while entries are buffered discards them
    step(1'b0, 1'b1, 1'b0, 6'd20, 32'hBAD0_0001);
    step(1'b0, 1'b0, 1'b1, 6'd61, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(2);
    check("after_reset_empty", 32'(sb_empty), 32'd1);
    check("mem20_untouched", dmem[20], 32'hC0DE_0000 + 32'd20);

    // random traffic; stalled requests are re-presented unchanged
    hold = 1'b0; pw = 1'b0; pr = 1'b0; ra = '0; rd = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'b0, 1'b0, '0, '0);
        hold = 1'b0;
        continue;
      end
      if (!hold) begin
        pw = ($urandom_range(0, 99) < 50);
        pr = ($urandom_range(0, 99) < 40);
        if (pw && pr && $urandom_range(0, 3) != 0) pw = 1'b0;
        ra = ($urandom_range(0, 9) == 0) ? 6'd60 : 6'($urandom_range(0, 7));
        rd = $urandom;
      end
      step(1'b0, pw, pr, ra, rd);
      hold = last_stall && !(pw && pr);
    end
    idle(DEPTH + 2);
    check("final_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), dmem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
